// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: pixel coordinates, strobes and the delayed VGA pins.
// The timing generator drives it through the master modport; the drawing logic uses slave.
interface vga_timing_gen_if;
  logic        pixelTick;
  logic [15:0] screenX;
  logic [15:0] screenY;
  logic        visibleArea;
  logic        vSyncStart;
  logic        vgaHS;
  logic        vgaVS;
  logic        vgaBlankN;

  modport master (
    output pixelTick, screenX, screenY, visibleArea, vSyncStart, vgaHS, vgaVS, vgaBlankN
  );

  modport slave (
    input pixelTick, screenX, screenY, visibleArea, vSyncStart, vgaHS, vgaVS, vgaBlankN
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: pixel-rate enable, X/Y counters, frame strobe and sync pins
// delayed to line up with the registered pixel colour produced downstream.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE  = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned PIPE_DELAY = 3
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  vga_timing_gen_if.master  o_vga
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DivW-1:0] DivMax  = DivW'(CLK_DIV - 1);
  localparam logic [15:0]     HLast   = 16'(H_TOTAL - 1);
  localparam logic [15:0]     VLast   = 16'(V_TOTAL - 1);
  localparam logic [15:0]     HVis    = 16'(H_VISIBLE);
  localparam logic [15:0]     VVis    = 16'(V_VISIBLE);
  localparam logic [15:0]     HSyncLo = 16'(H_VISIBLE + H_FRONT);
  localparam logic [15:0]     HSyncHi = 16'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [15:0]     VSyncLo = 16'(V_VISIBLE + V_FRONT);
  localparam logic [15:0]     VSyncHi = 16'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [DivW-1:0] r_div;
  logic            r_tick;
  logic [15:0]     r_x;
  logic [15:0]     r_y;
  logic            r_vis;
  logic            r_vss;

  logic        w_tick_d;
  logic [15:0] w_x_d;
  logic [15:0] w_y_d;
  logic        w_hs;
  logic        w_vs;

  // Coordinates of the next pixel; only committed on a tick edge.
  always_comb begin
    w_tick_d = (r_div == DivMax);
    w_x_d    = r_x + 16'd1;
    w_y_d    = r_y;
    if (r_x == HLast) begin
      w_x_d = '0;
      w_y_d = (r_y == VLast) ? '0 : r_y + 16'd1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_div  <= '0;
      r_tick <= 1'b0;
      r_x    <= HLast;
      r_y    <= VLast;
      r_vis  <= 1'b0;
      r_vss  <= 1'b0;
    end else begin
      r_div  <= w_tick_d ? '0 : r_div + DivW'(1);
      r_tick <= w_tick_d;
      r_vss  <= 1'b0;
      if (w_tick_d) begin
        r_x   <= w_x_d;
        r_y   <= w_y_d;
        r_vis <= (w_x_d < HVis) && (w_y_d < VVis);
        r_vss <= (w_x_d == '0) && (w_y_d == VVis);
      end
    end
  end

  always_comb begin
    w_hs = !((r_x >= HSyncLo) && (r_x < HSyncHi));
    w_vs = !((r_y >= VSyncLo) && (r_y < VSyncHi));
  end

  assign o_vga.pixelTick   = r_tick;
  assign o_vga.screenX     = r_x;
  assign o_vga.screenY     = r_y;
  assign o_vga.visibleArea = r_vis;
  assign o_vga.vSyncStart  = r_vss;

  generate
    if (PIPE_DELAY == 0) begin : g_no_pipe
      assign o_vga.vgaHS     = w_hs;
      assign o_vga.vgaVS     = w_vs;
      assign o_vga.vgaBlankN = r_vis;
    end else begin : g_pipe
      logic [PIPE_DELAY-1:0] r_hs_pipe;
      logic [PIPE_DELAY-1:0] r_vs_pipe;
      logic [PIPE_DELAY-1:0] r_bn_pipe;

      // Free-running shift, not gated by the pixel enable, so the delay is in system clocks.
      always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
          r_hs_pipe <= '1;
          r_vs_pipe <= '1;
          r_bn_pipe <= '0;
        end else begin
          r_hs_pipe[0] <= w_hs;
          r_vs_pipe[0] <= w_vs;
          r_bn_pipe[0] <= r_vis;
          for (int i = 1; i < int'(PIPE_DELAY); i++) begin
            r_hs_pipe[i] <= r_hs_pipe[i-1];
            r_vs_pipe[i] <= r_vs_pipe[i-1];
            r_bn_pipe[i] <= r_bn_pipe[i-1];
          end
        end
      end

      assign o_vga.vgaHS     = r_hs_pipe[PIPE_DELAY-1];
      assign o_vga.vgaVS     = r_vs_pipe[PIPE_DELAY-1];
      assign o_vga.vgaBlankN = r_bn_pipe[PIPE_DELAY-1];
    end
  endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three parameterisations share one clock and reset; expected
// raster state is derived from elapsed clock count since reset release.
module tb_vga_timing_gen;

  typedef struct packed {
    logic        tick;
    logic [15:0] x;
    logic [15:0] y;
    logic        vis;
    logic        vss;
    logic        hs;
    logic        vs;
    logic        bn;
  } snap_t;

  typedef struct {
    int hv, hf, hsw, hb, vv, vf, vsw, vb, d, p;
  } mode_t;

  logic CLOCK_50 = 1'b0;
  logic rst_n    = 1'b0;
  int   n        = 0;
  int   checks   = 0;
  int   failures = 0;
  int   hold     = 0;
  int   last_small = -1;
  int   last_odd   = -1;

  snap_t q_exp[3][$];

  always #5 CLOCK_50 = ~CLOCK_50;

  vga_timing_gen_if if_def ();
  vga_timing_gen_if if_small ();
  vga_timing_gen_if if_odd ();

  vga_timing_gen u_def (
    .CLOCK_50 (CLOCK_50),
    .resetn   (rst_n),
    .o_vga    (if_def)
  );

  vga_timing_gen #(
    .H_VISIBLE (4), .H_FRONT (1), .H_SYNC (1), .H_BACK (1),
    .V_VISIBLE (3), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
    .CLK_DIV   (1), .PIPE_DELAY (0)
  ) u_small (
    .CLOCK_50 (CLOCK_50),
    .resetn   (rst_n),
    .o_vga    (if_small)
  );

  vga_timing_gen #(
    .H_VISIBLE (5), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
    .V_VISIBLE (4), .V_FRONT (1), .V_SYNC (2), .V_BACK (1),
    .CLK_DIV   (3), .PIPE_DELAY (2)
  ) u_odd (
    .CLOCK_50 (CLOCK_50),
    .resetn   (rst_n),
    .o_vga    (if_odd)
  );

  snap_t act[3];
  assign act[0] = {if_def.pixelTick, if_def.screenX, if_def.screenY, if_def.visibleArea,
                   if_def.vSyncStart, if_def.vgaHS, if_def.vgaVS, if_def.vgaBlankN};
  assign act[1] = {if_small.pixelTick, if_small.screenX, if_small.screenY,
                   if_small.visibleArea, if_small.vSyncStart, if_small.vgaHS, if_small.vgaVS,
                   if_small.vgaBlankN};
  assign act[2] = {if_odd.pixelTick, if_odd.screenX, if_odd.screenY, if_odd.visibleArea,
                   if_odd.vSyncStart, if_odd.vgaHS, if_odd.vgaVS, if_odd.vgaBlankN};

  // Clock edges seen since the last reset release.
  always @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) n <= 0;
    else        n <= n + 1;
  end

  function automatic mode_t mode_of(input int i);
    mode_t m;
    case (i)
      0:       m = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 3};
      1:       m = '{4, 1, 1, 1, 3, 1, 1, 1, 1, 0};
      default: m = '{5, 2, 3, 2, 4, 1, 2, 1, 3, 2};
    endcase
    return m;
  endfunction

  // Raster position after c edges: tick k lands on pixel k-1 of the frame sequence.
  function automatic void coords(input mode_t m, input int c, output int x, output int y,
                                 output bit tick);
    int ht, vt, pos;
    ht = m.hv + m.hf + m.hsw + m.hb;
    vt = m.vv + m.vf + m.vsw + m.vb;
    if (c < m.d) begin
      x = ht - 1;
      y = vt - 1;
      tick = 1'b0;
    end else begin
      pos  = (c / m.d - 1) % (ht * vt);
      x    = pos % ht;
      y    = pos / ht;
      tick = (c % m.d) == 0;
    end
  endfunction

  function automatic snap_t model(input mode_t m, input int c);
    snap_t s;
    int x, y, px, py;
    bit t, pt;
    coords(m, c, x, y, t);
    s.tick = t;
    s.x    = 16'(x);
    s.y    = 16'(y);
    s.vis  = (x < m.hv) && (y < m.vv);
    s.vss  = t && (x == 0) && (y == m.vv);
    if (c < m.p) begin
      s.hs = 1'b1;
      s.vs = 1'b1;
      s.bn = 1'b0;
    end else begin
      coords(m, c - m.p, px, py, pt);
      s.hs = !((px >= m.hv + m.hf) && (px < m.hv + m.hf + m.hsw));
      s.vs = !((py >= m.vv + m.vf) && (py < m.vv + m.vf + m.vsw));
      s.bn = (px < m.hv) && (py < m.vv);
    end
    return s;
  endfunction

  task automatic compare(input string name, input snap_t a, input snap_t e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s t=%0t n=%0d act tick=%b x=%0d y=%0d vis=%b vss=%b hs=%b vs=%b bn=%b | exp tick=%b x=%0d y=%0d vis=%b vss=%b hs=%b vs=%b bn=%b",
               name, $time, n, a.tick, a.x, a.y, a.vis, a.vss, a.hs, a.vs, a.bn,
               e.tick, e.x, e.y, e.vis, e.vss, e.hs, e.vs, e.bn);
    end
  endtask

  task automatic check_int(input string name, input int a, input int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s t=%0t act=%0d exp=%0d", name, $time, a, e);
    end
  endtask

  // Monitor: pops one expectation per instance each cycle and measures frame-strobe spacing.
  always @(negedge CLOCK_50) begin
    for (int k = 0; k < 3; k++) begin
      if (q_exp[k].size() > 0) compare($sformatf("sb%0d", k), act[k], q_exp[k].pop_front());
    end
    if (!rst_n) begin
      last_small = -1;
      last_odd   = -1;
    end else begin
      if (if_small.vSyncStart) begin
        if (last_small >= 0) check_int("small_vss_period", n - last_small, 42);
        last_small = n;
      end
      if (if_odd.vSyncStart) begin
        if (last_odd >= 0) check_int("odd_vss_period", n - last_odd, 288);
        last_odd = n;
      end
    end
  end

  initial begin
    snap_t rst_def;
    rst_def = {1'b0, 16'd799, 16'd524, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    repeat (3) @(posedge CLOCK_50);
    #1;
    compare("reset_def", act[0], rst_def);
    compare("reset_small", act[1], model(mode_of(1), 0));
    compare("reset_odd", act[2], model(mode_of(2), 0));
    @(negedge CLOCK_50);
    #2 rst_n = 1'b1;

    for (int c = 0; c < 12000; c++) begin
      @(posedge CLOCK_50);
      #1;
      for (int k = 0; k < 3; k++) q_exp[k].push_back(model(mode_of(k), n));
      @(negedge CLOCK_50);
      #2;
      if (rst_n) begin
        if (c == 6000 || (c > 4000 && $urandom_range(0, 1499) == 0)) begin
          rst_n = 1'b0;
          hold  = $urandom_range(1, 6);
          #1;
          compare("async_def", act[0], rst_def);
          compare("async_small", act[1], model(mode_of(1), 0));
          compare("async_odd", act[2], model(mode_of(2), 0));
        end
      end else if (hold == 0) begin
        rst_n = 1'b1;
      end else begin
        hold--;
      end
    end

    @(negedge CLOCK_50);
    #1;
    for (int k = 0; k < 3; k++) check_int($sformatf("drain%0d", k), q_exp[k].size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
